// File: rtl/sopc_cpu_div_cell_if.sv
// sopc_cpu_div_cell_if
// Request/response bundle between the CPU A stage and the iterative divider cell.
// The CPU side drives operands and start; the divider returns busy, the done
// pulse and the registered quotient/remainder.
interface sopc_cpu_div_cell_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] A_div_src1;    // dividend, sampled on start
  logic [DATA_W-1:0] A_div_src2;    // divisor, sampled on start
  logic              A_div_signed;  // two's-complement operands, sampled on start
  logic              A_div_start;   // request, accepted only while idle
  logic              A_div_busy;    // high while an operation is in flight
  logic              A_div_done;    // one-cycle result-valid pulse
  logic [DATA_W-1:0] A_div_quot;    // quotient, held until the next done
  logic [DATA_W-1:0] A_div_rem;     // remainder, held until the next done

  // CPU side
  modport master (
    output A_div_src1,
    output A_div_src2,
    output A_div_signed,
    output A_div_start,
    input  A_div_busy,
    input  A_div_done,
    input  A_div_quot,
    input  A_div_rem
  );

  // Divider side
  modport slave (
    input  A_div_src1,
    input  A_div_src2,
    input  A_div_signed,
    input  A_div_start,
    output A_div_busy,
    output A_div_done,
    output A_div_quot,
    output A_div_rem
  );

endinterface

// File: rtl/sopc_cpu_div_cell.sv
// sopc_cpu_div_cell
// Iterative radix-2 restoring integer divider for the Nios II CPU.
// One quotient bit per clock: start in IDLE, DATA_W steps in CALC, then a
// FIXUP cycle that applies sign correction and pulses done.
// Divide-by-zero goes straight to FIXUP and returns quot = all ones,
// rem = dividend exactly as presented.
// Signed division truncates toward zero; the remainder takes the dividend's sign.
// Optional feature macro: SOPC_CPU_DIV_SIGNED_EN
//   defined   -> A_div_signed honoured (abs on load, negate in FIXUP)
//   undefined -> every operation is unsigned, sign logic is not built
module sopc_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sopc_cpu_div_cell_if.slave   div_if
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rem_work_reg;   // partial remainder
  logic [DATA_W-1:0] quot_work_reg;  // dividend shifting out / quotient shifting in
  logic [DATA_W-1:0] divisor_reg;    // magnitude of the divisor
  logic              div0_reg;       // current operation is a divide-by-zero
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] quot_reg;
  logic [DATA_W-1:0] rem_reg;

  // Values loaded into the datapath when a start is accepted.
  logic [DATA_W-1:0] load_dividend;
  logic [DATA_W-1:0] load_divisor;
  logic              divisor_zero;

  // Sign-corrected results presented to the output registers in FIXUP.
  logic [DATA_W-1:0] fix_quot;
  logic [DATA_W-1:0] fix_rem;

  // Restoring step datapath.
  logic [DATA_W:0]   step_partial;
  logic              step_ge;
  logic [DATA_W-1:0] step_diff;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quot;

  // Two's-complement negation; abs(MIN) naturally lands on unsigned 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] value);
    negate = {DATA_W{1'b0}} - value;
  endfunction

  assign divisor_zero = (div_if.A_div_src2 == {DATA_W{1'b0}});

`ifdef SOPC_CPU_DIV_SIGNED_EN
  logic load_neg1;
  logic load_neg2;
  logic sign_q_reg;   // quotient must be negated
  logic sign_r_reg;   // remainder must be negated (follows the dividend)

  assign load_neg1     = div_if.A_div_signed & div_if.A_div_src1[DATA_W-1];
  assign load_neg2     = div_if.A_div_signed & div_if.A_div_src2[DATA_W-1];
  assign load_dividend = load_neg1 ? negate(div_if.A_div_src1) : div_if.A_div_src1;
  assign load_divisor  = load_neg2 ? negate(div_if.A_div_src2) : div_if.A_div_src2;
  assign fix_quot      = sign_q_reg ? negate(quot_work_reg) : quot_work_reg;
  assign fix_rem       = sign_r_reg ? negate(rem_work_reg)  : rem_work_reg;

  // Latch the result signs at start; they are only consumed in FIXUP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && div_if.A_div_start) begin
      sign_q_reg <= load_neg1 ^ load_neg2;
      sign_r_reg <= load_neg1;
    end
  end
`else
  // Signed requests are treated as unsigned in this build.
  logic unused_signed;

  assign unused_signed = div_if.A_div_signed;
  assign load_dividend = div_if.A_div_src1;
  assign load_divisor  = div_if.A_div_src2;
  assign fix_quot      = quot_work_reg;
  assign fix_rem       = rem_work_reg;
`endif

  // Shift {rem,quot} left by one and trial-subtract the divisor from the
  // DATA_W+1-bit partial remainder. The partial is always < 2*divisor, so a
  // successful difference always fits back into DATA_W bits.
  assign step_partial = {rem_work_reg, quot_work_reg[DATA_W-1]};
  assign step_ge      = (step_partial >= {1'b0, divisor_reg});
  assign step_diff    = step_partial[DATA_W-1:0] - divisor_reg;
  assign step_rem     = step_ge ? step_diff : step_partial[DATA_W-1:0];
  assign step_quot    = {quot_work_reg[DATA_W-2:0], step_ge};

  // Control FSM and datapath registers; all handshake outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rem_work_reg  <= '0;
      quot_work_reg <= '0;
      divisor_reg   <= '0;
      div0_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quot_reg      <= '0;
      rem_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (div_if.A_div_start) begin
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
            rem_work_reg <= '0;
            if (divisor_zero) begin
              // Keep the raw dividend so it can be returned untouched.
              div0_reg      <= 1'b1;
              quot_work_reg <= div_if.A_div_src1;
              divisor_reg   <= '0;
              state_reg     <= ST_FIXUP;
            end else begin
              div0_reg      <= 1'b0;
              quot_work_reg <= load_dividend;
              divisor_reg   <= load_divisor;
              state_reg     <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          rem_work_reg  <= step_rem;
          quot_work_reg <= step_quot;
          cnt_reg       <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= ST_FIXUP;
          end
        end

        ST_FIXUP: begin
          if (div0_reg) begin
            quot_reg <= {DATA_W{1'b1}};
            rem_reg  <= quot_work_reg;
          end else begin
            quot_reg <= fix_quot;
            rem_reg  <= fix_rem;
          end
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign div_if.A_div_busy = busy_reg;
  assign div_if.A_div_done = done_reg;
  assign div_if.A_div_quot = quot_reg;
  assign div_if.A_div_rem  = rem_reg;

endmodule

// File: tb/tb_sopc_cpu_div_cell.sv
// tb_sopc_cpu_div_cell
// Directed bench for the divider cell. Expected quotient/remainder/latency are
// computed from native 64-bit arithmetic and queued when a start is driven;
// they are popped and compared when done is seen. Expectations follow
// SOPC_CPU_DIV_SIGNED_EN so the bench works in either build.
module tb_sopc_cpu_div_cell;

  localparam int W = 32;

`ifdef SOPC_CPU_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    int           lat;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  sopc_cpu_div_cell_if #(.DATA_W(W)) div_if ();

  sopc_cpu_div_cell #(.DATA_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div_if  (div_if.slave)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference division: truncate toward zero, remainder follows dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (SIGNED_EN && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Handshake invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      assert (!(div_if.A_div_done && div_if.A_div_busy) && !(div_if.A_div_done && prev_done)) else begin
        errors++;
        $error("FAIL handshake: observed done=%0b busy=%0b prev_done=%0b expected single done with busy low",
               div_if.A_div_done, div_if.A_div_busy, prev_done);
      end
    end
    prev_done = div_if.A_div_done;
  end

  // Drive one operation from a falling edge and wait for its result.
  // inject_at > 0: present a second start (different operands) at that cycle.
  // abort_at  > 0: pull reset_n low at that cycle and check the abort.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input string tag, input int inject_at, input int abort_at);
    exp_t e;
    int   seen;
    bit   got;
    model(a, b, sgn, e.quot, e.rem);
    e.lat = (b == '0) ? 1 : W + 1;
    e.tag = tag;
    sb_q.push_back(e);
    div_if.A_div_src1   = a;
    div_if.A_div_src2   = b;
    div_if.A_div_signed = sgn;
    div_if.A_div_start  = 1'b1;
    got  = 1'b0;
    seen = 0;
    for (int cnt = 1; cnt <= 120; cnt++) begin
      @(negedge clk);
      seen = cnt;
      if (cnt == 1) begin
        div_if.A_div_start  = 1'b0;
        div_if.A_div_src1   = $urandom;
        div_if.A_div_src2   = $urandom;
        div_if.A_div_signed = ~sgn;
        check({tag, "_busy"}, W'(div_if.A_div_busy), W'(1));
      end
      if (inject_at > 0 && cnt == inject_at) begin
        div_if.A_div_src1   = 32'd1000;
        div_if.A_div_src2   = 32'd3;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_start  = 1'b1;
      end
      if (inject_at > 0 && cnt == inject_at + 1) begin
        div_if.A_div_start = 1'b0;
      end
      if (abort_at > 0 && cnt == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_abort_busy"}, W'(div_if.A_div_busy), W'(0));
        check({tag, "_abort_done"}, W'(div_if.A_div_done), W'(0));
        check({tag, "_abort_quot"}, div_if.A_div_quot, '0);
        check({tag, "_abort_rem"},  div_if.A_div_rem,  '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (div_if.A_div_done) seen++;
        end
        check({tag, "_abort_no_done"}, W'(seen), W'(0));
        void'(sb_q.pop_front());
        $display("op %s: aborted by reset, no result", tag);
        return;
      end
      if (div_if.A_div_done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, W'(got), W'(1));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, W'(0), W'(1));
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_lat"},  W'(seen - 1), W'(e.lat));
    check({e.tag, "_quot"}, div_if.A_div_quot, e.quot);
    check({e.tag, "_rem"},  div_if.A_div_rem,  e.rem);
    $display("op %s: a=0x%08h b=0x%08h signed=%0b quot=0x%08h rem=0x%08h latency=%0d",
             e.tag, a, b, sgn, div_if.A_div_quot, div_if.A_div_rem, seen - 1);
  endtask

  initial begin
    int extra;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    div_if.A_div_src1   = '0;
    div_if.A_div_src2   = '0;
    div_if.A_div_signed = 1'b0;
    div_if.A_div_start  = 1'b0;

    // Reset values
    #1;
    check("rst_busy", W'(div_if.A_div_busy), W'(0));
    check("rst_done", W'(div_if.A_div_done), W'(0));
    check("rst_quot", div_if.A_div_quot, '0);
    check("rst_rem",  div_if.A_div_rem,  '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back calls: each new start lands in the previous done cycle.
    run_op(32'd100,       32'd7,        1'b0, "u_100_7",     0, 0);
    run_op(32'hFFFF_FFF9, 32'd2,        1'b1, "s_m7_2",      0, 0);
    run_op(32'd7,         32'hFFFF_FFFE, 1'b1, "s_7_m2",     0, 0);
    run_op(32'hFFFF_FFF9, 32'd2,        1'b0, "u_fff9_2",    0, 0);
    run_op(32'h1234_5678, 32'd0,        1'b0, "dz_u",        0, 0);
    run_op(32'h1234_5678, 32'd0,        1'b1, "dz_s",        0, 0);
    run_op(32'hFFFF_FFF9, 32'd0,        1'b1, "dz_s_neg",    0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1",   0, 0);
    run_op(32'hFFFF_FFFF, 32'd1,        1'b0, "u_max_1",     0, 0);
    run_op(32'd5,         32'd9,        1'b0, "u_small",     0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min_min",  0, 0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i < 2) ? W'($urandom_range(1, 1000)) : W'($urandom);
      run_op(ra, rb, i[0], $sformatf("rand%0d", i), 0, 0);
    end

    // Start while busy is ignored; only the first result comes back.
    run_op(32'd100, 32'd7, 1'b0, "ignored_start", 5, 0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (div_if.A_div_done) extra++;
    end
    check("ignored_no_2nd_done", W'(extra), W'(0));

    // Reset in the middle of an operation.
    run_op(32'hDEAD_BEEF, 32'd3, 1'b0, "abort", 0, 10);

    // Recovery after the abort.
    run_op(32'd1000, 32'd10, 1'b0, "recover", 0, 0);

    check("sb_empty", W'(sb_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
